// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with a 2-bit bimodal
//               counter per entry. Lookup is zero-latency, the table is
//               trained by resolved branches/jumps, and the whole table can
//               be invalidated by a sequenced one-entry-per-cycle sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    // fetch-side lookup
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    // resolution-side update
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_is_jump,
    // table invalidate
    input  logic            inv_req,
    output logic            busy
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = XLEN - IDX_BITS - 2;
    localparam logic [IDX_BITS-1:0] C_LAST_IDX = IDX_BITS'(ENTRIES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_swp;

    // Table storage: control bits are reset, tag/target are data-only.
    logic [ENTRIES-1:0]    r_valid;
    logic [ENTRIES-1:0]    r_jump;
    logic [1:0]            r_ctr    [ENTRIES];
    logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]       r_target [ENTRIES];

    logic [IDX_BITS-1:0]   w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic [IDX_BITS-1:0]   w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic                  w_upd_en;
    logic                  w_alloc;
    logic                  w_hit_upd;
    logic                  w_wr_target;
    logic [1:0]            w_ctr_next;
    logic                  w_unused;

    // Byte offset within the instruction word carries no information here.
    assign w_unused = ^upd_pc[1:0];

    assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
    assign w_lk_tag = lookup_pc[XLEN-1:IDX_BITS+2];
    assign w_up_idx = upd_pc[IDX_BITS+1:2];
    assign w_up_tag = upd_pc[XLEN-1:IDX_BITS+2];

    assign busy = (r_state == ST_SWEEP);

    // Lookup reads registered contents only, so a same-cycle update is
    // never bypassed to the fetch side.
    assign pred_hit    = !busy && r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit && (r_jump[w_lk_idx] || r_ctr[w_lk_idx][1]);
    assign pred_target = pred_taken ? r_target[w_lk_idx] : (lookup_pc + XLEN'(4));

    // Updates are accepted only while idle and not starting an invalidate.
    assign w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_upd_en    = upd_valid && (r_state == ST_IDLE) && !inv_req;
    assign w_alloc     = w_upd_en && !w_up_hit && upd_taken;
    assign w_hit_upd   = w_upd_en && w_up_hit;
    assign w_wr_target = w_alloc || (w_hit_upd && (upd_is_jump || upd_taken));

    // Next counter value for a hit: jumps pin it strongly taken, branches
    // move one step toward the outcome and saturate at either end.
    always_comb begin
        w_ctr_next = r_ctr[w_up_idx];
        if (upd_is_jump) begin
            w_ctr_next = 2'b11;
        end else if (upd_taken) begin
            if (r_ctr[w_up_idx] != 2'b11) begin
                w_ctr_next = r_ctr[w_up_idx] + 2'b01;
            end
        end else begin
            if (r_ctr[w_up_idx] != 2'b00) begin
                w_ctr_next = r_ctr[w_up_idx] - 2'b01;
            end
        end
    end

    // Sweep sequencer plus the reset-able per-entry control bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_swp   <= '0;
            r_valid <= '0;
            r_jump  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_INIT;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (inv_req) begin
                        r_state <= ST_SWEEP;
                        r_swp   <= '0;
                    end else if (w_alloc) begin
                        r_valid[w_up_idx] <= 1'b1;
                        r_jump[w_up_idx]  <= upd_is_jump;
                        r_ctr[w_up_idx]   <= upd_is_jump ? 2'b11 : 2'b10;
                    end else if (w_hit_upd) begin
                        r_ctr[w_up_idx] <= w_ctr_next;
                        if (upd_is_jump) begin
                            r_jump[w_up_idx] <= 1'b1;
                        end
                    end
                end
                ST_SWEEP: begin
                    r_valid[r_swp] <= 1'b0;
                    r_ctr[r_swp]   <= CTR_INIT;
                    r_swp          <= r_swp + 1'b1;
                    if (r_swp == C_LAST_IDX) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and target payload; qualified by valid so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_up_idx] <= w_up_tag;
        end
        if (w_wr_target) begin
            r_target[w_up_idx] <= upd_target;
        end
    end

endmodule
`default_nettype wire
